// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the 16x-oversampling UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Tick index inside the start bit where the line is re-checked (8th tick).
    localparam int START_SAMPLE = 7;
    // Oversample ticks per bit period.
    localparam int BIT_TICKS    = 16;
    // Data bits per frame.
    localparam int DATA_BITS    = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops, both preset to line-idle so reset never looks like a start bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive deserializer: start bit, 8 data bits LSB first, optional parity, one stop bit.
// Config macro: UART_RX_SYNC_EN -- when defined, rx passes through uart_rx_sync (adds 2 clk latency).
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int OVS_LOG2  = 4,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_enable,
    input  logic                 tick_baud_x16,
    input  logic                 parity_enable,
    input  logic                 parity_odd,
    input  logic                 rx,
    output logic                 tick_baud,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 idle,
    output logic                 frame_err,
    output logic                 rx_parity_err
);

    localparam logic [OVS_LOG2-1:0] START_TICK = OVS_LOG2'(START_SAMPLE);
    localparam logic [OVS_LOG2-1:0] LAST_TICK  = OVS_LOG2'(BIT_TICKS - 1);
    localparam logic [3:0]          LAST_BIT   = 4'(DATA_BITS - 1);

    rx_state_e             state_q, state_d;
    logic [OVS_LOG2-1:0]   tick_cnt_q, tick_cnt_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS:0]    shift_q;
    logic                  par_en_q, par_odd_q;
    logic                  rx_s;
    logic                  start_det, shift_en, frame_done;
    logic [DATA_BITS-1:0]  frame_byte;
    logic                  frame_pbit;

    // Odd/even parity check over data plus received parity bit.
    function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] d,
                                             input logic p,
                                             input logic odd);
        return (^d) ^ p ^ odd;
    endfunction

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_rx_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d      (rx),
        .q      (rx_s)
    );
`else
    assign rx_s = rx;
`endif

    // With parity the last shift pushes data one place further down.
    assign frame_byte = par_en_q ? shift_q[DATA_BITS-1:0] : shift_q[DATA_BITS:1];
    assign frame_pbit = shift_q[DATA_BITS];
    assign idle       = (state_q == IDLE);

    // Next-state, counters and per-tick sample strobes.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tick_baud  = 1'b0;
        start_det  = 1'b0;
        shift_en   = 1'b0;
        frame_done = 1'b0;
        if (!rx_enable) begin
            state_d = IDLE;
        end else if (tick_baud_x16) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
            unique case (state_q)
                IDLE: begin
                    tick_cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = START;
                        start_det = 1'b1;
                    end
                end
                START: begin
                    if (tick_cnt_q == START_TICK) begin
                        tick_baud  = 1'b1;
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (tick_cnt_q == LAST_TICK) begin
                        tick_baud = 1'b1;
                        shift_en  = 1'b1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = par_en_q ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (tick_cnt_q == LAST_TICK) begin
                        tick_baud = 1'b1;
                        shift_en  = 1'b1;
                        state_d   = STOP;
                    end
                end
                STOP: begin
                    if (tick_cnt_q == LAST_TICK) begin
                        tick_baud  = 1'b1;
                        frame_done = 1'b1;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control state: FSM, counters, and frame format captured at start detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            if (start_det) begin
                par_en_q  <= parity_enable;
                par_odd_q <= parity_odd;
            end
        end
    end

    // Shift register collects data (and parity) bits, newest entering at the top.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
        end else if (shift_en) begin
            shift_q <= {rx_s, shift_q[DATA_BITS:1]};
        end
    end

    // Output flops: one-cycle strobes after the stop sample; rx_data holds between frames.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_valid      <= 1'b0;
            frame_err     <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_data       <= '0;
        end else begin
            rx_valid      <= frame_done;
            frame_err     <= frame_done & ~rx_s;
            rx_parity_err <= frame_done & par_en_q &
                             parity_mismatch(frame_byte, frame_pbit, par_odd_q);
            if (frame_done) begin
                rx_data <= frame_byte;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: table of whole frames plus hand-written corner sequences.
module tb_uart_rx_core;

`ifdef UART_RX_SYNC_EN
    localparam int SYNC_DLY = 2;
`else
    localparam int SYNC_DLY = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_enable = 1'b1;
    logic       tick_baud_x16 = 1'b1;
    logic       parity_enable = 1'b0;
    logic       parity_odd = 1'b0;
    logic       rx = 1'b1;
    logic       tick_baud;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       idle;
    logic       frame_err;
    logic       rx_parity_err;

    int cyc = 0;
    int div = 1;
    int tick_phase = 0;
    int checks = 0;
    int errors = 0;
    int start_cyc = 0;

    int   total_valid = 0;
    int   total_ticks = 0;
    int   total_orphan = 0;
    int   last_valid_cyc = 0;
    logic last_fe = 1'b0;
    logic last_pe = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_odd;
        logic       pbit;
        logic       stop;
        int         div;
        logic [7:0] exp_data;
        logic       exp_fe;
        logic       exp_pe;
        int         exp_ticks;
        int         exp_lat;
    } vec_t;

    vec_t vecs[8];

    uart_rx_core dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .rx_enable     (rx_enable),
        .tick_baud_x16 (tick_baud_x16),
        .parity_enable (parity_enable),
        .parity_odd    (parity_odd),
        .rx            (rx),
        .tick_baud     (tick_baud),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .idle          (idle),
        .frame_err     (frame_err),
        .rx_parity_err (rx_parity_err)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Oversample tick: every clk when div=1, else one clk in div.
    initial forever begin
        @(posedge clk);
        #1;
        tick_phase = (tick_phase + 1) % div;
        tick_baud_x16 = (div == 1) || (tick_phase == 0);
    end

    always @(negedge clk) begin
        if (rx_valid) begin
            total_valid    <= total_valid + 1;
            last_fe        <= frame_err;
            last_pe        <= rx_parity_err;
            last_valid_cyc <= cyc;
        end
        if (tick_baud) total_ticks <= total_ticks + 1;
        if ((frame_err || rx_parity_err) && !rx_valid) total_orphan <= total_orphan + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic align_tick();
        do begin
            @(posedge clk);
            #2;
        end while (!tick_baud_x16);
    endtask

    // Drives one complete frame; parity controls are flipped after the start bit
    // so that only the values present at start detection may matter.
    task automatic send_frame(input vec_t v);
        int bt;
        bt = 16 * v.div;
        parity_enable = v.par_en;
        parity_odd    = v.par_odd;
        align_tick();
        start_cyc = cyc;
        rx = 1'b0;
        hold(bt);
        parity_enable = ~v.par_en;
        parity_odd    = ~v.par_odd;
        for (int b = 0; b < 8; b++) begin
            rx = v.data[b];
            hold(bt);
        end
        if (v.par_en) begin
            rx = v.pbit;
            hold(bt);
        end
        rx = v.stop;
        hold(bt);
        rx = 1'b1;
        parity_enable = v.par_en;
        parity_odd    = v.par_odd;
        hold(32 * v.div);
    endtask

    initial begin
        int v0, t0, adj;

        vecs[0] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1, 8'h55, 1'b0, 1'b0, 10, 153};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1, 8'hA5, 1'b0, 1'b0, 11, 169};
        vecs[2] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1, 8'hA5, 1'b0, 1'b1, 11, 169};
        vecs[3] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1, 8'h3C, 1'b0, 1'b0, 11, 169};
        vecs[4] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1, 8'h3C, 1'b0, 1'b1, 11, 169};
        vecs[5] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1, 8'h3C, 1'b1, 1'b0, 11, 153};
        vecs[6] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 8'h00, 1'b1, 1'b0, 11, 153};
        vecs[7] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 4, 8'h81, 1'b0, 1'b0, 10, 609};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_idle", idle, 1);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 8'h00);
        check("rst_ferr", frame_err, 0);
        check("rst_perr", rx_parity_err, 0);
        check("rst_tick_baud", tick_baud, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        hold(4);

        // Frame table
        for (int i = 0; i < 8; i++) begin
            div = vecs[i].div;
            hold(8);
            v0 = total_valid;
            t0 = total_ticks;
            send_frame(vecs[i]);
            adj = (SYNC_DLY == 0) ? 0 : ((SYNC_DLY + div - 1) / div) * div;
            check($sformatf("v%0d_valid_cnt", i), total_valid - v0, 1);
            check($sformatf("v%0d_data", i), rx_data, vecs[i].exp_data);
            check($sformatf("v%0d_ferr", i), last_fe, vecs[i].exp_fe);
            check($sformatf("v%0d_perr", i), last_pe, vecs[i].exp_pe);
            check($sformatf("v%0d_ticks", i), total_ticks - t0, vecs[i].exp_ticks);
            check($sformatf("v%0d_latency", i), last_valid_cyc - start_cyc, vecs[i].exp_lat + adj);
            check($sformatf("v%0d_idle", i), idle, 1);
        end
        div = 1;
        hold(8);

        // Short low glitch: one false-start sample, nothing received
        v0 = total_valid;
        t0 = total_ticks;
        align_tick();
        rx = 1'b0;
        repeat (SYNC_DLY) @(posedge clk);
        @(negedge clk);
        check("glitch_idle_before_detect", idle, 1);
        @(negedge clk);
        check("glitch_idle_after_detect", idle, 0);
        repeat (4 - (SYNC_DLY + 1)) @(posedge clk);
        #2;
        rx = 1'b1;
        hold(40);
        check("glitch_valid_cnt", total_valid - v0, 0);
        check("glitch_ticks", total_ticks - t0, 1);
        check("glitch_idle", idle, 1);

        // rx_enable dropped during bit 3 of 8'hFF
        v0 = total_valid;
        t0 = total_ticks;
        align_tick();
        rx = 1'b0;
        hold(16);
        rx = 1'b1;
        hold(16 * 3 + 4);
        rx_enable = 1'b0;
        hold(2);
        check("endrop_idle_now", idle, 1);
        hold(20);
        rx_enable = 1'b1;
        hold(200);
        check("endrop_valid_cnt", total_valid - v0, 0);
        check("endrop_ticks", total_ticks - t0, 4);
        check("endrop_data_held", rx_data, 8'h81);
        check("endrop_idle", idle, 1);

        // Reset in the middle of a frame
        v0 = total_valid;
        align_tick();
        rx = 1'b0;
        hold(40);
        rst_n = 1'b0;
        hold(1);
        check("midrst_idle", idle, 1);
        check("midrst_data", rx_data, 8'h00);
        check("midrst_valid", rx_valid, 0);
        rx = 1'b1;
        hold(2);
        rst_n = 1'b1;
        hold(200);
        check("midrst_valid_cnt", total_valid - v0, 0);
        check("midrst_idle_after", idle, 1);

        check("orphan_error_strobes", total_orphan, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
